// File: rtl/pcheck_if.sv
// Show-ahead FIFO read port between the receive FIFO (master) and the packet checker (slave).
interface pcheck_if #(
    parameter int unsigned DATA_W = 64
);
    logic              fifo_ne;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_re;

    modport master (output fifo_ne, output fifo_rd_data, input fifo_re);
    modport slave  (input fifo_ne, input fifo_rd_data, output fifo_re);
endinterface

// File: rtl/pcheck.sv
// Random-packet checker: SOP/header/payload framing, sequence and lane-content checks, saturating stats.
// Optional first-mismatch capture is built when PCHECK_CAPTURE_EN is defined.
module pcheck #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned PKT_WORDS = 512,
    parameter int unsigned SEQ_W     = 32,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                         clk,
    input  logic                         reset_l,
    input  logic                         clr,
    pcheck_if.slave                      fifo,
    output logic [CNT_W-1:0]             packet_count,
    output logic [CNT_W-1:0]             good_count,
    output logic [CNT_W-1:0]             error_count,
    output logic [CNT_W-1:0]             content_count,
    output logic [CNT_W-1:0]             short_count,
    output logic [CNT_W-1:0]             seq_count,
    output logic [CNT_W-1:0]             junk_count,
    output logic                         cap_valid,
    output logic [SEQ_W-1:0]             cap_seq,
    output logic [$clog2(PKT_WORDS)-1:0] cap_index,
    output logic [DATA_W-1:0]            cap_expected,
    output logic [DATA_W-1:0]            cap_actual
);

    localparam int unsigned NL = DATA_W / 16;
    localparam int unsigned IW = $clog2(PKT_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD
    } state_t;

    state_t            state;
    logic [IW-1:0]     cnt;
    logic [SEQ_W-1:0]  last_seq;
    logic [DATA_W-1:0] exp_word;
    logic              perr;
    logic              cseen;

    logic packet_p, good_p, content_p, short_p, seq_p, junk_p, err_p;

    logic [DATA_W-1:0] word;
    logic              is_sop;
    logic              mismatch;
    logic [SEQ_W-1:0]  hdr_seq;
    logic [SEQ_W-1:0]  seq_inc;

    // Lane k of the next expected word is seed+k+1; lane 0 sits in bits [15:0].
    function automatic logic [DATA_W-1:0] lanes_after(input logic [15:0] seed);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int unsigned k = 0; k < NL; k++) begin
            w[16*k +: 16] = seed + 16'(k + 1);
        end
        return w;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic p);
        return (p && (c != '1)) ? c + CNT_W'(1) : c;
    endfunction

    assign fifo.fifo_re = fifo.fifo_ne;
    assign word         = fifo.fifo_rd_data;
    assign is_sop       = &word;
    assign mismatch     = (word != exp_word);
    assign hdr_seq      = word[SEQ_W-1:0];
    assign seq_inc      = last_seq + SEQ_W'(1);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state     <= IDLE;
            cnt       <= '0;
            last_seq  <= '1;
            exp_word  <= '0;
            perr      <= 1'b0;
            cseen     <= 1'b0;
            packet_p  <= 1'b0;
            good_p    <= 1'b0;
            content_p <= 1'b0;
            short_p   <= 1'b0;
            seq_p     <= 1'b0;
            junk_p    <= 1'b0;
            err_p     <= 1'b0;
        end else begin
            packet_p  <= 1'b0;
            good_p    <= 1'b0;
            content_p <= 1'b0;
            short_p   <= 1'b0;
            seq_p     <= 1'b0;
            junk_p    <= 1'b0;
            err_p     <= 1'b0;
            if (fifo.fifo_ne) begin
                if (is_sop) begin
                    state    <= HDR;
                    cnt      <= IW'(PKT_WORDS - 3);
                    packet_p <= 1'b1;
                    perr     <= 1'b0;
                    cseen    <= 1'b0;
                    short_p  <= (state != IDLE);
                    err_p    <= (state != IDLE);
                end else begin
                    case (state)
                        HDR: begin
                            last_seq <= hdr_seq;
                            exp_word <= lanes_after(word[DATA_W-1 -: 16]);
                            state    <= PAYLOAD;
                            if (hdr_seq != seq_inc) begin
                                seq_p <= 1'b1;
                                err_p <= 1'b1;
                                perr  <= 1'b1;
                            end
                        end
                        PAYLOAD: begin
                            // Expectation chains from the previous expectation, never from received data.
                            exp_word <= lanes_after(exp_word[DATA_W-1 -: 16]);
                            if (mismatch) begin
                                perr  <= 1'b1;
                                cseen <= 1'b1;
                                if (!cseen) begin
                                    content_p <= 1'b1;
                                    err_p     <= 1'b1;
                                end
                            end
                            if (cnt == '0) begin
                                state  <= IDLE;
                                good_p <= !(perr || mismatch);
                            end else begin
                                cnt <= cnt - IW'(1);
                            end
                        end
                        default: junk_p <= 1'b1;
                    endcase
                end
            end
            if (clr) begin
                packet_p  <= 1'b0;
                good_p    <= 1'b0;
                content_p <= 1'b0;
                short_p   <= 1'b0;
                seq_p     <= 1'b0;
                junk_p    <= 1'b0;
                err_p     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            packet_count  <= '0;
            good_count    <= '0;
            error_count   <= '0;
            content_count <= '0;
            short_count   <= '0;
            seq_count     <= '0;
            junk_count    <= '0;
        end else if (clr) begin
            packet_count  <= '0;
            good_count    <= '0;
            error_count   <= '0;
            content_count <= '0;
            short_count   <= '0;
            seq_count     <= '0;
            junk_count    <= '0;
        end else begin
            packet_count  <= sat_inc(packet_count, packet_p);
            good_count    <= sat_inc(good_count, good_p);
            error_count   <= sat_inc(error_count, err_p);
            content_count <= sat_inc(content_count, content_p);
            short_count   <= sat_inc(short_count, short_p);
            seq_count     <= sat_inc(seq_count, seq_p);
            junk_count    <= sat_inc(junk_count, junk_p);
        end
    end

`ifdef PCHECK_CAPTURE_EN
    logic [SEQ_W-1:0]  mm_seq;
    logic [IW-1:0]     mm_index;
    logic [DATA_W-1:0] mm_exp;
    logic [DATA_W-1:0] mm_act;

    // Stage the details alongside content_p so the capture lines up with the counter update.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            mm_seq   <= '0;
            mm_index <= '0;
            mm_exp   <= '0;
            mm_act   <= '0;
        end else if (fifo.fifo_ne && !is_sop && (state == PAYLOAD) && mismatch && !cseen) begin
            mm_seq   <= last_seq;
            mm_index <= IW'(PKT_WORDS - 3) - cnt;
            mm_exp   <= exp_word;
            mm_act   <= word;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            cap_valid    <= 1'b0;
            cap_seq      <= '0;
            cap_index    <= '0;
            cap_expected <= '0;
            cap_actual   <= '0;
        end else if (clr) begin
            cap_valid    <= 1'b0;
            cap_seq      <= '0;
            cap_index    <= '0;
            cap_expected <= '0;
            cap_actual   <= '0;
        end else if (content_p && !cap_valid) begin
            cap_valid    <= 1'b1;
            cap_seq      <= mm_seq;
            cap_index    <= mm_index;
            cap_expected <= mm_exp;
            cap_actual   <= mm_act;
        end
    end
`else
    assign cap_valid    = 1'b0;
    assign cap_seq      = '0;
    assign cap_index    = '0;
    assign cap_expected = '0;
    assign cap_actual   = '0;
`endif

endmodule

// File: tb/tb_pcheck.sv
// Directed self-checking bench for pcheck: a 32-bit-counter and a 4-bit-counter instance share one word stream.
module tb_pcheck;

    localparam int unsigned DW = 64;
    localparam int unsigned PW = 512;
    localparam int unsigned SW = 32;
    localparam int unsigned NP = PW - 2;

    logic          clk = 1'b0;
    logic          reset_l = 1'b0;
    logic          clr = 1'b0;
    logic          ne = 1'b0;
    logic [DW-1:0] data = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pcheck_if #(.DATA_W(DW)) bus32 ();
    pcheck_if #(.DATA_W(DW)) bus4 ();

    assign bus32.fifo_ne      = ne;
    assign bus32.fifo_rd_data = data;
    assign bus4.fifo_ne       = ne;
    assign bus4.fifo_rd_data  = data;

    logic [31:0] pc, gc, ec, cc, sc, qc, jc;
    logic [3:0]  pc4, gc4, ec4, cc4, sc4, qc4, jc4;
    logic          cv, cv4;
    logic [SW-1:0] cs, cs4;
    logic [8:0]    ci, ci4;
    logic [DW-1:0] ce, ca, ce4, ca4;

    pcheck #(.DATA_W(DW), .PKT_WORDS(PW), .SEQ_W(SW), .CNT_W(32)) dut32 (
        .clk(clk), .reset_l(reset_l), .clr(clr), .fifo(bus32),
        .packet_count(pc), .good_count(gc), .error_count(ec), .content_count(cc),
        .short_count(sc), .seq_count(qc), .junk_count(jc),
        .cap_valid(cv), .cap_seq(cs), .cap_index(ci), .cap_expected(ce), .cap_actual(ca)
    );

    pcheck #(.DATA_W(DW), .PKT_WORDS(PW), .SEQ_W(SW), .CNT_W(4)) dut4 (
        .clk(clk), .reset_l(reset_l), .clr(clr), .fifo(bus4),
        .packet_count(pc4), .good_count(gc4), .error_count(ec4), .content_count(cc4),
        .short_count(sc4), .seq_count(qc4), .junk_count(jc4),
        .cap_valid(cv4), .cap_seq(cs4), .cap_index(ci4), .cap_expected(ce4), .cap_actual(ca4)
    );

    // Order: packet, good, error, content, short, seq, junk.
    function automatic logic [223:0] c32();
        return {pc, gc, ec, cc, sc, qc, jc};
    endfunction

    function automatic logic [27:0] c4();
        return {pc4, gc4, ec4, cc4, sc4, qc4, jc4};
    endfunction

    function automatic logic [223:0] exp32(input int p, g, e, c, s, q, j);
        return {32'(p), 32'(g), 32'(e), 32'(c), 32'(s), 32'(q), 32'(j)};
    endfunction

    // Payload word j of a packet: lane l = seed + 4*j + l + 1 (mod 2^16).
    function automatic logic [DW-1:0] pay(input logic [15:0] seed, input int j);
        logic [DW-1:0] w;
        for (int l = 0; l < 4; l++) w[16*l +: 16] = seed + 16'(j * 4 + l + 1);
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ne = 1'b0;
        repeat (n) step();
    endtask

    task automatic word(input logic [DW-1:0] w);
        ne   = 1'b1;
        data = w;
        step();
        ne   = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic send_packet(input logic [31:0] seq, input logic [15:0] seed, input int n,
                               input int bad1, input int bad2, input bit gaps);
        logic [DW-1:0] w;
        word('1);
        word({seed, 16'h0000, seq});
        for (int j = 0; j < n; j++) begin
            w = pay(seed, j);
            if (j == bad1 || j == bad2) w = w ^ 64'h1;
            word(w);
            if (gaps && (j % 7 == 3)) idle(1);
        end
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        ne = 1'b0;
        repeat (2) step();
        checks++;
        if (c32() !== '0) begin
            errors++; $display("FAIL reset_counts: got %h expected 0", c32());
        end
        checks++;
        if (bus32.fifo_re !== 1'b0) begin
            errors++; $display("FAIL reset_re_low: got %b expected 0", bus32.fifo_re);
        end
        ne = 1'b1; data = '1;
        #1;
        checks++;
        if (bus32.fifo_re !== 1'b1) begin
            errors++; $display("FAIL reset_re_high: got %b expected 1", bus32.fifo_re);
        end
        ne = 1'b0;
        checks++;
        if ({cv, cs, ci, ce, ca} !== '0) begin
            errors++; $display("FAIL reset_cap: got valid=%b seq=%h idx=%0d expected all 0", cv, cs, ci);
        end
        reset_l = 1'b1;
        step();
    endtask

    task automatic test_clean();
        send_packet(32'd0, 16'h1234, NP, -1, -1, 1'b1);
        word('1);
        word({16'h1234, 16'h0000, 32'd1});
        word(64'h1238_1237_1236_1235);
        for (int j = 1; j < int'(NP); j++) word(pay(16'h1234, j));
        checks++;
        if (gc !== 32'd1) begin
            errors++; $display("FAIL clean_good_latency1: got %0d expected 1", gc);
        end
        step();
        checks++;
        if (gc !== 32'd2) begin
            errors++; $display("FAIL clean_good_latency2: got %0d expected 2", gc);
        end
        idle(2);
        checks++;
        if (c32() !== exp32(2, 2, 0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL clean_counts: got %h expected %h", c32(), exp32(2, 2, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_content();
        do_clr();
        send_packet(32'd2, 16'hFFF0, NP, -1, -1, 1'b0);
        send_packet(32'd3, 16'h00F0, NP, 10, 20, 1'b0);
        idle(3);
        checks++;
        if (c32() !== exp32(2, 1, 1, 1, 0, 0, 0)) begin
            errors++; $display("FAIL content_counts: got %h expected %h", c32(), exp32(2, 1, 1, 1, 0, 0, 0));
        end
`ifdef PCHECK_CAPTURE_EN
        checks++;
        if ({cv, cs, ci} !== {1'b1, 32'd3, 9'd10}) begin
            errors++; $display("FAIL content_cap_loc: got valid=%b seq=%0d idx=%0d expected 1 3 10", cv, cs, ci);
        end
        checks++;
        if ({ce, ca} !== {pay(16'h00F0, 10), pay(16'h00F0, 10) ^ 64'h1}) begin
            errors++; $display("FAIL content_cap_data: got exp=%h act=%h expected %h %h",
                               ce, ca, pay(16'h00F0, 10), pay(16'h00F0, 10) ^ 64'h1);
        end
`else
        checks++;
        if ({cv, cs, ci, ce, ca} !== '0) begin
            errors++; $display("FAIL content_cap_off: got valid=%b seq=%0d idx=%0d expected all 0", cv, cs, ci);
        end
`endif
        do_clr();
        step();
        checks++;
        if ({cv, c32()} !== '0) begin
            errors++; $display("FAIL content_clr: got valid=%b counts=%h expected all 0", cv, c32());
        end
    endtask

    task automatic test_seq();
        send_packet(32'd4, 16'h0101, NP, -1, -1, 1'b0);
        send_packet(32'd9, 16'h2020, NP, -1, -1, 1'b0);
        send_packet(32'd10, 16'h3030, NP, -1, -1, 1'b0);
        idle(3);
        checks++;
        if (c32() !== exp32(3, 2, 1, 0, 0, 1, 0)) begin
            errors++; $display("FAIL seq_counts: got %h expected %h", c32(), exp32(3, 2, 1, 0, 0, 1, 0));
        end
    endtask

    task automatic test_short();
        do_clr();
        send_packet(32'd11, 16'h4444, 100, -1, -1, 1'b0);
        send_packet(32'd12, 16'h5555, NP, -1, -1, 1'b0);
        idle(3);
        checks++;
        if (c32() !== exp32(2, 1, 1, 0, 1, 0, 0)) begin
            errors++; $display("FAIL short_counts: got %h expected %h", c32(), exp32(2, 1, 1, 0, 1, 0, 0));
        end
    endtask

    task automatic test_junk_reset();
        send_packet(32'd13, 16'h6666, 5, -1, -1, 1'b0);
        reset_l = 1'b0;
        step();
        reset_l = 1'b1;
        step();
        word(64'h1); word(64'h2); word(64'h3);
        checks++;
        if (jc !== 32'd2) begin
            errors++; $display("FAIL junk_latency1: got %0d expected 2", jc);
        end
        idle(2);
        checks++;
        if (c32() !== exp32(0, 0, 0, 0, 0, 0, 3)) begin
            errors++; $display("FAIL junk_counts: got %h expected %h", c32(), exp32(0, 0, 0, 0, 0, 0, 3));
        end
        ne = 1'b1; data = 64'h4; clr = 1'b1;
        step();
        ne = 1'b0; clr = 1'b0;
        checks++;
        if (jc !== 32'd0) begin
            errors++; $display("FAIL junk_clr1: got %0d expected 0", jc);
        end
        step();
        checks++;
        if (jc !== 32'd0) begin
            errors++; $display("FAIL junk_clr2: got %0d expected 0", jc);
        end
        send_packet(32'd0, 16'h7777, NP, -1, -1, 1'b0);
        idle(3);
        checks++;
        if (c32() !== exp32(1, 1, 0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL reset_seq0: got %h expected %h", c32(), exp32(1, 1, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_back_to_back();
        do_clr();
        for (int i = 1; i <= 20; i++) send_packet(32'(i), 16'(i * 37), NP, -1, -1, 1'b0);
        send_packet(32'hFFFF_FFFF, 16'h8888, NP, -1, -1, 1'b0);
        send_packet(32'd0, 16'h9999, NP, -1, -1, 1'b0);
        idle(3);
        checks++;
        if (c32() !== exp32(22, 21, 1, 0, 0, 1, 0)) begin
            errors++; $display("FAIL b2b_counts32: got %h expected %h", c32(), exp32(22, 21, 1, 0, 0, 1, 0));
        end
        checks++;
        if (c4() !== {4'd15, 4'd15, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0}) begin
            errors++; $display("FAIL b2b_sat4: got %h expected %h", c4(), {4'd15, 4'd15, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0});
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_content();
        test_seq();
        test_short();
        test_junk_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
